spi_ram_port: RTL

SPI_RAM_PORT -- requirements
Module: spi_ram_port

---
 rtl/spi_ram_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_ram_port.sv
// SPI RAM port: serialises {cmd, addr, data} read/write frames to an SPI SRAM (mode 0, clk/2).
// Latency: busy for 2N+1 cycles per transaction, N = 8+ADDR_BITS+8*DATA_WIDTH_BYTES frame bits.
// Backpressure: starts are accepted only while idle (busy=0); starts seen while busy are dropped.
// Optional SPI_RAM_INIT_EN: after reset, send WRMR 0x01,0x40 before accepting requests.
module spi_ram_port #(
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ADDR_BITS        = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
  input  logic                          start_read,
  input  logic                          start_write,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          busy,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  output logic                          spi_mosi,
  input  logic                          spi_miso
);

  localparam int DW = 8 * DATA_WIDTH_BYTES;
  localparam int N  = 8 + ADDR_BITS + DW;
  localparam int CW = $clog2(N + 1);
  localparam logic [7:0] CMD_RD = 8'h03;
  localparam logic [7:0] CMD_WR = 8'h02;

`ifdef SPI_RAM_INIT_EN
  localparam int          INIT_BITS  = 16;
  localparam logic [15:0] INIT_FRAME = 16'h0140;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, INIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t          state, state_d;
  logic            phase;      // 0 = SPI clock low phase, 1 = high phase
  logic [CW-1:0]   bit_cnt;
  logic [N-1:0]    tx_sr;
  logic [DW-1:0]   rx_sr;
  logic [DW-1:0]   rx_next;
  logic            is_read;
  logic            load_frame;
  logic            shifting;
  logic            frame_end;
`ifdef SPI_RAM_INIT_EN
  logic            init_pending;
  logic            load_init;
`endif

  // Byte 0 travels first on the wire but lives in the low byte of the parallel buses.
  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) r[8*i +: 8] = v[DW-8-8*i +: 8];
    return r;
  endfunction

  assign spi_mosi = tx_sr[N-1];
  assign rx_next  = {rx_sr[DW-2:0], spi_miso};

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and per-state outputs; a frame ends on the edge closing its last high phase.
  always_comb begin
    state_d     = state;
    busy        = 1'b1;
    spi_select  = 1'b0;
    spi_clk_out = 1'b0;
    load_frame  = 1'b0;
    shifting    = 1'b0;
    frame_end   = 1'b0;
`ifdef SPI_RAM_INIT_EN
    load_init   = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy       = 1'b0;
        spi_select = 1'b1;
`ifdef SPI_RAM_INIT_EN
        if (init_pending) begin
          load_init = 1'b1;
          state_d   = INIT;
        end else
`endif
        if (start_read || start_write) begin
          load_frame = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        spi_clk_out = phase;
        shifting    = 1'b1;
        if (phase && bit_cnt == CW'(N - 1)) begin
          frame_end = 1'b1;
          state_d   = DONE;
        end
      end
`ifdef SPI_RAM_INIT_EN
      INIT: begin
        spi_clk_out = phase;
        shifting    = 1'b1;
        if (phase && bit_cnt == CW'(INIT_BITS - 1)) begin
          frame_end = 1'b1;
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        spi_select = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame load, bit shifting, MISO capture and read-data delivery.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase    <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      is_read  <= 1'b0;
      data_out <= '0;
`ifdef SPI_RAM_INIT_EN
      init_pending <= 1'b1;
`endif
    end else if (load_frame) begin
      // Write wins when both starts arrive together; reads send a zero data field.
      tx_sr   <= {start_write ? CMD_WR : CMD_RD, addr_in,
                  start_write ? byte_swap(data_in) : {DW{1'b0}}};
      is_read <= !start_write;
      phase   <= 1'b0;
      bit_cnt <= '0;
`ifdef SPI_RAM_INIT_EN
    end else if (load_init) begin
      tx_sr        <= {INIT_FRAME, {(N - INIT_BITS){1'b0}}};
      is_read      <= 1'b0;
      init_pending <= 1'b0;
      phase        <= 1'b0;
      bit_cnt      <= '0;
`endif
    end else if (shifting) begin
      phase <= !phase;
      if (phase) begin
        tx_sr   <= {tx_sr[N-2:0], 1'b0};
        rx_sr   <= rx_next;
        bit_cnt <= frame_end ? '0 : bit_cnt + CW'(1);
        if (frame_end && is_read) data_out <= byte_swap(rx_next);
      end
    end
  end

endmodule
